// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming F x F sliding-window generator with stride S.
// Consumes a raster-order pixel stream and keeps F-1 previous rows in line
// buffers. Each window whose origin lies on the stride grid is emitted as one
// flattened word.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pix_in/pix_valid    input pixel stream; pix_ready is the acceptance strobe
//   win_out/win_valid   registered window; element (r,c) at [((r*F)+c)*datawidth +: datawidth]
//   win_ready           downstream accepts the window
//   frame_done          one-cycle pulse after the last pixel of a frame is accepted
module conv_window_gen #(
    parameter int unsigned N         = 5,
    parameter int unsigned F         = 3,
    parameter int unsigned S         = 1,
    parameter int unsigned datawidth = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [datawidth-1:0]      pix_in,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    output logic [F*F*datawidth-1:0]  win_out,
    output logic                      win_valid,
    input  logic                      win_ready,
    output logic                      frame_done
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = (S > 1) ? $clog2(S) : 1;
    localparam int unsigned WW = F * F * datawidth;

    logic [CW-1:0]        row;
    logic [CW-1:0]        col;
    logic [PW-1:0]        row_phase;
    logic [PW-1:0]        col_phase;
    logic [datawidth-1:0] line_buf [F-1][N];
    logic [datawidth-1:0] win      [F][F];
    logic [datawidth-1:0] col_new  [F];
    logic [WW-1:0]        win_next;
    logic                 accept;
    logic                 emit;
    logic                 col_last;
    logic                 row_last;

    // Any stall on the output also stalls non-emitting pixels so the line
    // buffers never run ahead of the window register.
    assign pix_ready = !win_valid || win_ready;
    assign accept    = pix_valid && pix_ready;
    assign col_last  = (col == CW'(N - 1));
    assign row_last  = (row == CW'(N - 1));
    assign emit      = accept && (row >= CW'(F - 1)) && (col >= CW'(F - 1))
                       && (row_phase == '0) && (col_phase == '0);

    // Incoming column (oldest row at r=0) and the shifted window it produces.
    always_comb begin
        win_next = '0;
        for (int r = 0; r < int'(F) - 1; r++) begin
            col_new[r] = line_buf[int'(F) - 2 - r][col];
        end
        col_new[F-1] = pix_in;
        for (int r = 0; r < int'(F); r++) begin
            for (int c = 0; c < int'(F) - 1; c++) begin
                win_next[((r*F)+c)*datawidth +: datawidth] = win[r][c+1];
            end
            win_next[((r*F)+F-1)*datawidth +: datawidth] = col_new[r];
        end
    end

    // Line buffers and window register; contents need no reset because they
    // are refilled before the first window of a frame is emitted.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = int'(F) - 2; k >= 1; k--) begin
                line_buf[k][col] <= line_buf[k-1][col];
            end
            line_buf[0][col] <= pix_in;
            for (int r = 0; r < int'(F); r++) begin
                for (int c = 0; c < int'(F); c++) begin
                    win[r][c] <= win_next[((r*F)+c)*datawidth +: datawidth];
                end
            end
        end
    end

    // Raster counters, stride phases and the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row        <= '0;
            col        <= '0;
            row_phase  <= '0;
            col_phase  <= '0;
            win_valid  <= 1'b0;
            win_out    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && col_last && row_last;
            if (accept) begin
                col <= col_last ? '0 : col + CW'(1);
                // Column phase restarts each row; it only runs once col reaches F-1.
                if (col_last) begin
                    col_phase <= '0;
                end else if (col >= CW'(F - 1)) begin
                    col_phase <= (col_phase == PW'(S - 1)) ? '0 : col_phase + PW'(1);
                end
                if (col_last) begin
                    row <= row_last ? '0 : row + CW'(1);
                    if (row_last) begin
                        row_phase <= '0;
                    end else if (row >= CW'(F - 1)) begin
                        row_phase <= (row_phase == PW'(S - 1)) ? '0 : row_phase + PW'(1);
                    end
                end
            end
            if (emit) begin
                win_valid <= 1'b1;
                win_out   <= win_next;
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: three parameterisations share one
// stimulus driver, selected by sel (0: N5 F3 S1, 1: N5 F3 S2, 2: N4 F2 S3).
module tb_conv_window_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pix_in;
    logic        pv;
    logic        wr;
    int          sel;

    logic        pr0, wv0, fd0;
    logic [71:0] wo0;
    logic        pr1, wv1, fd1;
    logic [71:0] wo1;
    logic        pr2, wv2, fd2;
    logic [31:0] wo2;

    logic        m_pix_ready, m_win_valid, m_frame_done;
    logic [71:0] m_win_out;

    logic [71:0] got_q[$];
    logic [71:0] exp_q[$];
    int          fd_cnt;
    int          checks;
    int          failures;
    bit          ramp_mode;

    localparam logic [71:0] W_FIRST = 72'h0C0B0A_070605_020100;
    localparam logic [71:0] W_LAST  = 72'h181716_131211_0E0D0C;
    localparam logic [71:0] W_MIN   = 72'h05040100;

    always #5 clk = ~clk;

    conv_window_gen #(.N(5), .F(3), .S(1), .datawidth(8)) u_s1 (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pv && sel == 0),
        .pix_ready(pr0), .win_out(wo0), .win_valid(wv0), .win_ready(wr),
        .frame_done(fd0));

    conv_window_gen #(.N(5), .F(3), .S(2), .datawidth(8)) u_s2 (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pv && sel == 1),
        .pix_ready(pr1), .win_out(wo1), .win_valid(wv1), .win_ready(wr),
        .frame_done(fd1));

    conv_window_gen #(.N(4), .F(2), .S(3), .datawidth(8)) u_min (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pv && sel == 2),
        .pix_ready(pr2), .win_out(wo2), .win_valid(wv2), .win_ready(wr),
        .frame_done(fd2));

    always_comb begin
        m_pix_ready  = pr0;
        m_win_valid  = wv0;
        m_frame_done = fd0;
        m_win_out    = wo0;
        case (sel)
            1: begin m_pix_ready = pr1; m_win_valid = wv1; m_frame_done = fd1; m_win_out = wo1; end
            2: begin m_pix_ready = pr2; m_win_valid = wv2; m_frame_done = fd2; m_win_out = 72'(wo2); end
            default: ;
        endcase
    end

    // Record every output handshake and frame_done pulse of the selected DUT.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_win_valid && wr) got_q.push_back(m_win_out);
            if (m_frame_done) fd_cnt++;
        end
    end

    function automatic int pn();
        return (sel == 2) ? 4 : 5;
    endfunction
    function automatic int pf();
        return (sel == 2) ? 2 : 3;
    endfunction
    function automatic int ps();
        return (sel == 0) ? 1 : ((sel == 1) ? 2 : 3);
    endfunction

    function automatic logic [7:0] pixval(input int idx);
        int n2, f, p;
        n2 = pn() * pn();
        f  = idx / n2;
        p  = idx % n2;
        return ramp_mode ? 8'(p) : 8'(f * 37 + p * 7 + 3);
    endfunction

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: cut every stride-aligned window straight out of the image.
    task automatic build_exp(input int nframes);
        logic [71:0] w;
        int n, f, s;
        n = pn(); f = pf(); s = ps();
        exp_q.delete();
        for (int fr = 0; fr < nframes; fr++)
            for (int r0 = 0; r0 <= n - f; r0 += s)
                for (int c0 = 0; c0 <= n - f; c0 += s) begin
                    w = '0;
                    for (int r = 0; r < f; r++)
                        for (int c = 0; c < f; c++)
                            w[((r*f)+c)*8 +: 8] = pixval(fr*n*n + (r0+r)*n + c0 + c);
                    exp_q.push_back(w);
                end
    endtask

    task automatic clear_obs();
        got_q.delete();
        fd_cnt = 0;
    endtask

    task automatic run_frames(input int nframes, input int vpct, input int rpct, input bit hold);
        int idx, total, cyc;
        bit held;
        idx = 0; cyc = 0; held = 0;
        total = nframes * pn() * pn();
        while (idx < total && cyc < 5000) begin
            @(posedge clk); #1; cyc++;
            if (hold && !held && m_win_valid) begin
                held = 1;
                for (int k = 0; k < 5; k++) begin
                    pv = 1'b1; pix_in = pixval(idx); wr = 1'b0;
                    @(negedge clk);
                    check("hold_pix_ready", 72'(m_pix_ready), 72'(0));
                    check("hold_win_out", m_win_out, W_FIRST);
                    @(posedge clk); #1;
                end
            end
            pv     = ($urandom_range(0, 99) < vpct);
            pix_in = pixval(idx);
            wr     = ($urandom_range(0, 99) < rpct);
            @(negedge clk);
            if (pv && m_pix_ready) idx++;
        end
        check("stream_complete", 72'(idx), 72'(total));
        @(posedge clk); #1;
        pv = 1'b0; wr = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic compare_windows(input string tag);
        check({tag, "_count"}, 72'(got_q.size()), 72'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check(tag, got_q[i], exp_q[i]);
    endtask

    initial begin
        checks = 0; failures = 0; fd_cnt = 0;
        rst = 1'b1; pv = 1'b0; wr = 1'b0; pix_in = '0; sel = 0; ramp_mode = 1;
        #3;
        check("rst_pix_ready", 72'(pr0), 72'(1));
        check("rst_win_valid", 72'(wv0), 72'(0));
        check("rst_frame_done", 72'(fd0), 72'(0));
        check("rst_win_out", wo0, 72'(0));
        #9 rst = 1'b0;

        // Stride 1 ramp, always ready.
        sel = 0; ramp_mode = 1; clear_obs(); build_exp(1);
        run_frames(1, 100, 100, 0);
        check("s1_count", 72'(got_q.size()), 72'(9));
        if (got_q.size() == 9) begin
            check("s1_w0", got_q[0], W_FIRST);
            check("s1_w8", got_q[8], W_LAST);
        end
        check("s1_frame_done", 72'(fd_cnt), 72'(1));
        compare_windows("s1_model");

        // Stride 2: origins (0,0) (0,2) (2,0) (2,2).
        sel = 1; clear_obs(); build_exp(1);
        run_frames(1, 100, 100, 0);
        check("s2_count", 72'(got_q.size()), 72'(4));
        if (got_q.size() == 4) check("s2_w3", got_q[3], W_LAST);
        check("s2_frame_done", 72'(fd_cnt), 72'(1));
        compare_windows("s2_model");

        // Backpressure: output held for 5 cycles after the first window.
        sel = 0; clear_obs(); build_exp(1);
        run_frames(1, 100, 100, 1);
        compare_windows("bp_model");
        check("bp_frame_done", 72'(fd_cnt), 72'(1));

        // Random valid/ready over three back-to-back frames.
        ramp_mode = 0; clear_obs(); build_exp(3);
        run_frames(3, 60, 50, 0);
        check("rnd_count", 72'(got_q.size()), 72'(27));
        check("rnd_frame_done", 72'(fd_cnt), 72'(3));
        compare_windows("rnd_model");

        // Reset mid-frame after pixel 13 (an emitting pixel).
        ramp_mode = 1; clear_obs();
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            pv = 1'b1; pix_in = 8'(i); wr = 1'b1;
        end
        @(posedge clk); #1;
        pv = 1'b0;
        check("mid_win_valid_pre", 72'(m_win_valid), 72'(1));
        rst = 1'b1;
        #1;
        check("mid_win_valid_rst", 72'(m_win_valid), 72'(0));
        check("mid_win_out_rst", m_win_out, 72'(0));
        #2 rst = 1'b0;
        clear_obs(); build_exp(1);
        run_frames(1, 100, 100, 0);
        if (got_q.size() > 0) check("mid_w0", got_q[0], W_FIRST);
        compare_windows("mid_model");

        // N=4 F=2 S=3: only origin (0,0) fits inside the image.
        sel = 2; clear_obs(); build_exp(1);
        run_frames(1, 100, 100, 0);
        check("min_count", 72'(got_q.size()), 72'(1));
        if (got_q.size() > 0) check("min_w0", got_q[0], W_MIN);
        check("min_frame_done", 72'(fd_cnt), 72'(1));
        compare_windows("min_model");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
